multi_digit_display: RTL and testbench

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/display_pkg.sv | 43 ++++
 rtl/seg_decode.sv | 11 +
 rtl/multi_digit_display.sv | 203 ++++++++++++++++++++
 tb/tb_multi_digit_display.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared digit codes, FSM state type and active-low segment table for the multiplexed display.
package display_pkg;

    localparam logic [3:0] DASH  = 4'hE;
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RANGE  = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Active-low segments {a,b,c,d,e,f,g}, indexed by digit code; A-D render blank
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b1111111,  // F blank
        7'b1111110,  // E dash
        7'b1111111,  // D
        7'b1111111,  // C
        7'b1111111,  // B
        7'b1111111,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Maps a 4-bit digit code to active-low seven-segment drive (out[6]=a .. out[0]=g).
module seg_decode
    import display_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = SEG_LUT[i_code];

endmodule

// File: rtl/multi_digit_display.sv
// Multi-channel binary-to-BCD converter with time-multiplexed seven-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of in-range channels.
module multi_digit_display
    import display_pkg::*;
#(
    parameter int unsigned NUM_WIDTH    = 14,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [NUM_CH*NUM_WIDTH-1:0]   Number,
    input  logic                          Load,
    output logic                          Busy,
    output logic [6:0]                    out7,
    output logic [NUM_CH*DIGITS-1:0]      en_out
);

    localparam int unsigned NUM_DIG = NUM_CH * DIGITS;
    localparam int unsigned BCD_W   = DIGITS * 4;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIT_W   = $clog2(NUM_WIDTH + 1);
    localparam int unsigned SCAN_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [63:0] LIMIT   = pow10(DIGITS);

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_accept;
    logic                          w_store;
    logic                          w_commit;
    logic                          w_busy_nxt;

    logic [NUM_CH*NUM_WIDTH-1:0]   r_num;
    logic [CH_W-1:0]               r_ch;
    logic [BIT_W-1:0]              r_bit;
    logic [NUM_WIDTH-1:0]          r_bin;
    logic [BCD_W-1:0]              r_bcd;
    logic                          r_ovf;
    logic                          r_busy;
    logic [3:0]                    r_work [NUM_DIG];
    logic [3:0]                    r_disp [NUM_DIG];

    logic [NUM_WIDTH-1:0]          w_ch_val;
    logic [BCD_W-1:0]              w_bcd_adj;
    logic [BCD_W+NUM_WIDTH-1:0]    w_sh;
    logic [BCD_W-1:0]              w_bcd_sh;
    logic [NUM_WIDTH-1:0]          w_bin_sh;
    logic [3:0]                    w_dig [DIGITS];
    logic                          w_last;
    logic                          w_last_ch;

    logic [REFRESH_BITS-1:0]       r_refresh;
    logic [SCAN_W-1:0]             r_scan;
    logic [6:0]                    r_out7;
    logic [NUM_DIG-1:0]            r_en;
    logic [6:0]                    w_seg_c;

    assign w_last    = (r_bit == BIT_W'(NUM_WIDTH - 1));
    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (Load) w_next = RANGE;
            RANGE:   w_next = SHIFT;
            SHIFT:   if (w_last) w_next = w_last_ch ? COMMIT : RANGE;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        w_accept   = 1'b0;
        w_store    = 1'b0;
        w_commit   = 1'b0;
        w_busy_nxt = (w_next != IDLE);
        unique case (r_state)
            IDLE:    w_accept = Load;
            SHIFT:   w_store  = w_last;
            COMMIT:  w_commit = 1'b1;
            default: ;
        endcase
    end

    // Active channel select from the shadow capture
    always_comb begin
        w_ch_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) w_ch_val = r_num[c*NUM_WIDTH +: NUM_WIDTH];
        end
    end

    // One double-dabble step: add 3 to digits >= 5, then shift left
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
        w_sh     = {w_bcd_adj, r_bin} << 1;
        w_bcd_sh = w_sh[NUM_WIDTH +: BCD_W];
        w_bin_sh = w_sh[NUM_WIDTH-1:0];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;
`endif

    // Final digit codes for the channel just converted (MSD scanned first)
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
`endif
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            w_dig[d] = w_bcd_sh[d*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (w_lead && (w_dig[d] == 4'd0) && (d != 0)) w_dig[d] = BLANK;
            else                                          w_lead   = 1'b0;
`endif
            if (r_ovf) w_dig[d] = DASH;
        end
    end

    // Conversion datapath and buffers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_num  <= '0;
            r_ch   <= '0;
            r_bit  <= '0;
            r_bin  <= '0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                r_work[i] <= BLANK;
                r_disp[i] <= BLANK;
            end
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_num <= Number;
                r_ch  <= '0;
            end
            if (r_state == RANGE) begin
                r_bin <= w_ch_val;
                r_bcd <= '0;
                r_bit <= '0;
                r_ovf <= (64'(w_ch_val) >= LIMIT);
            end
            if (r_state == SHIFT) begin
                r_bin <= w_bin_sh;
                r_bcd <= w_bcd_sh;
                r_bit <= r_bit + BIT_W'(1);
            end
            if (w_store) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (r_ch == CH_W'(c)) r_work[c*DIGITS + d] <= w_dig[d];
                    end
                end
                r_ch <= r_ch + CH_W'(1);
            end
            if (w_commit) begin
                for (int i = 0; i < NUM_DIG; i++) r_disp[i] <= r_work[i];
            end
        end
    end

    seg_decode u_seg_decode (
        .i_code  (r_disp[r_scan]),
        .o_seg_c (w_seg_c)
    );

    // Free-running scan: dwell counter advances the digit index on wrap
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_refresh <= '0;
            r_scan    <= '0;
            r_out7    <= 7'b1111111;
            r_en      <= '1;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            if (&r_refresh) begin
                r_scan <= (r_scan == SCAN_W'(NUM_DIG - 1)) ? '0 : r_scan + SCAN_W'(1);
            end
            r_en   <= ~(NUM_DIG'(1) << r_scan);
            r_out7 <= w_seg_c;
        end
    end

    assign Busy   = r_busy;
    assign out7   = r_out7;
    assign en_out = r_en;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed self-checking bench for multi_digit_display (2 channels x 4 digits, 4-cycle dwell).
module tb_multi_digit_display;

    logic        Clk;
    logic        Rst_n;
    logic [27:0] Number;
    logic        Load;
    logic        Busy;
    logic [6:0]  out7;
    logic [7:0]  en_out;

    int total = 0;
    int bad   = 0;

    multi_digit_display #(
        .NUM_WIDTH    (14),
        .NUM_CH       (2),
        .DIGITS       (4),
        .REFRESH_BITS (2)
    ) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Number (Number),
        .Load   (Load),
        .Busy   (Busy),
        .out7   (out7),
        .en_out (en_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected codes per scan index, index 0 in the low nibble
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] EXP_1234_56  = 32'hFF56_1234;
    localparam logic [31:0] EXP_4321_789 = 32'hF789_4321;
    localparam logic [31:0] EXP_0_100    = 32'hF100_FFF0;
`else
    localparam logic [31:0] EXP_1234_56  = 32'h0056_1234;
    localparam logic [31:0] EXP_4321_789 = 32'h0789_4321;
    localparam logic [31:0] EXP_0_100    = 32'h0100_0000;
`endif

    function automatic logic [6:0] seg_exp(input logic [3:0] code);
        logic [6:0] lit;
        case (code)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hE: lit = 7'b0000001;
            default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Align to the start of index 0, then check each index for exactly four cycles
    task automatic check_scan(input string tag, input logic [31:0] codes);
        int         n;
        logic [7:0] e;
        n = 0;
        while (en_out !== 8'h7F && n < 200) begin @(negedge Clk); n++; end
        while (en_out === 8'h7F && n < 200) begin @(negedge Clk); n++; end
        check({tag, " sync"}, 32'(n < 200), 32'd1);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                e = ~(8'(1) << i);
                check({tag, " en"}, 32'(en_out), 32'(e));
                check({tag, " seg"}, 32'(out7), 32'(seg_exp(codes[i*4 +: 4])));
                @(negedge Clk);
            end
        end
        check({tag, " wrap"}, 32'(en_out), 32'h0000_00FE);
    endtask

    task automatic convert(input string tag, input logic [13:0] a, input logic [13:0] b,
                           input int glitch);
        int n;
        Number = {b, a};
        Load   = 1'b1;
        @(negedge Clk);
        Load   = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            if (n == glitch) begin
                Number = {14'd0, 14'd1};
                Load   = 1'b1;
            end
            @(negedge Clk);
            Load = 1'b0;
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd31);
    endtask

    initial begin
        Rst_n  = 1'b0;
        Load   = 1'b0;
        Number = '0;
        repeat (2) @(negedge Clk);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst out7", 32'(out7), 32'h7F);
        check("rst en", 32'(en_out), 32'hFF);

        Rst_n = 1'b1;
        @(negedge Clk);
        check("post_rst en", 32'(en_out), 32'hFE);
        check("post_rst out7", 32'(out7), 32'h7F);
        check_scan("blank0", 32'hFFFF_FFFF);

        convert("c1234", 14'd1234, 14'd56, 0);
        check_scan("s1234", EXP_1234_56);

        convert("covf", 14'd10000, 14'd9999, 0);
        check_scan("sovf", 32'h9999_EEEE);

        convert("cign", 14'd4321, 14'd789, 5);
        check_scan("sign", EXP_4321_789);

        // Abort a conversion partway through the first channel's shifting
        Number = {14'd7, 14'd42};
        Load   = 1'b1;
        @(negedge Clk);
        Load   = 1'b0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort out7", 32'(out7), 32'h7F);
        check("abort en", 32'(en_out), 32'hFF);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("abort en0", 32'(en_out), 32'hFE);
        check("abort busy2", 32'(Busy), 32'd0);
        check_scan("sabort", 32'hFFFF_FFFF);

        convert("c0_100", 14'd0, 14'd100, 0);
        check_scan("s0_100", EXP_0_100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
